// File: rtl/fir_filter.sv
// Direct-form FIR on a signed sample stream, with fixed coefficients and a saturated, registered output.
// Latency is 1 cycle from x_in to y_out. There is no backpressure: one sample is consumed on every clock edge.
module fir_filter #(
  parameter int N_TAPS = 8,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16,
  parameter logic signed [N_TAPS*COEF_W-1:0] COEFFS =
    {8'sd1, 8'sd3, 8'sd7, 8'sd12, 8'sd12, 8'sd7, 8'sd3, 8'sd1}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x_in,
  output logic signed [OUT_W-1:0]  y_out
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(N_TAPS);
  localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  // Output clip limits, widened so they can be compared against the accumulator.
  localparam logic signed [EXT_W-1:0] Y_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] Y_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [DATA_W-1:0] d_q [N_TAPS-1];
  logic signed [DATA_W-1:0] d_d [N_TAPS-1];
  logic signed [DATA_W-1:0] tap [N_TAPS];
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [EXT_W-1:0]  acc_ext;
  logic signed [OUT_W-1:0]  y_q;
  logic signed [OUT_W-1:0]  y_d;

  always_comb begin
    tap[0] = x_in;
    d_d[0] = x_in;
    for (int k = 1; k < N_TAPS; k++) begin
      tap[k] = d_q[k-1];
    end
    for (int k = 1; k < N_TAPS-1; k++) begin
      d_d[k] = d_q[k-1];
    end
  end

  always_comb begin
    acc  = '0;
    prod = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      prod = PROD_W'(tap[k]) * PROD_W'($signed(COEFFS[k*COEF_W +: COEF_W]));
      acc  = acc + ACC_W'(prod);
    end
    acc_ext = EXT_W'(acc);
    if (acc_ext > Y_MAX) begin
      y_d = Y_MAX[OUT_W-1:0];
    end else if (acc_ext < Y_MIN) begin
      y_d = Y_MIN[OUT_W-1:0];
    end else begin
      y_d = acc_ext[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_TAPS-1; k++) begin
        d_q[k] <= '0;
      end
      y_q <= '0;
    end else begin
      for (int k = 0; k < N_TAPS-1; k++) begin
        d_q[k] <= d_d[k];
      end
      y_q <= y_d;
    end
  end

  assign y_out = y_q;

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: a default-coefficient instance, plus an all-127 instance that exercises saturation.
module tb_fir_filter;

  localparam logic signed [63:0] C_DEF = {8'sd1, 8'sd3, 8'sd7, 8'sd12, 8'sd12, 8'sd7, 8'sd3, 8'sd1};
  localparam logic signed [63:0] C_SAT = {8{8'sd127}};

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] x_in, x_sat;
  logic signed [15:0] y_out, y_sat;

  int cd[8] = '{1, 3, 7, 12, 12, 7, 3, 1};
  int cs[8] = '{default: 127};
  int hd[8];
  int hs[8];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int x;
    int exp;
    bit chk;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  fir_filter #(.COEFFS(C_DEF)) u_def (.clk(clk), .rst(rst), .x_in(x_in),  .y_out(y_out));
  fir_filter #(.COEFFS(C_SAT)) u_sat (.clk(clk), .rst(rst), .x_in(x_sat), .y_out(y_sat));

  function automatic int sat16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference output: the sum of the coefficients times the recent sample history (newest first), then clipped.
  function automatic int ref_y(int h[8], int c[8]);
    int s = 0;
    for (int k = 0; k < 8; k++) s += c[k] * h[k];
    return sat16(s);
  endfunction

  task automatic check(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 8; k++) begin
      hd[k] = 0;
      hs[k] = 0;
    end
  endtask

  task automatic step(int x, int xs);
    x_in  = 8'(x);
    x_sat = 8'(xs);
    @(posedge clk);
    for (int k = 7; k > 0; k--) begin
      hd[k] = hd[k-1];
      hs[k] = hs[k-1];
    end
    hd[0] = x;
    hs[0] = xs;
    #1;
  endtask

  task automatic check_model(string name);
    check({name, "_def"}, int'(y_out), ref_y(hd, cd));
    check({name, "_sat"}, int'(y_sat), ref_y(hs, cs));
  endtask

  // Reset is asserted between edges, and the outputs must clear before any edge arrives.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check("async_rst_def", int'(y_out), 0);
    check("async_rst_sat", int'(y_sat), 0);
    #1 rst = 1'b0;
    clear_model();
  endtask

  initial begin
    rst   = 1'b1;
    x_in  = 8'sd55;
    x_sat = 8'sd55;
    clear_model();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_hold_def", int'(y_out), 0);
      check("rst_hold_sat", int'(y_sat), 0);
    end
    rst = 1'b0;

    tbl.push_back('{1, 1, 1});
    foreach (cd[i]) if (i > 0) tbl.push_back('{0, cd[i], 1});
    tbl.push_back('{0, 0, 1});
    tbl.push_back('{0, 0, 1});
    tbl.push_back('{-128, -128, 1});
    foreach (cd[i]) if (i > 0) tbl.push_back('{0, -128 * cd[i], 1});
    tbl.push_back('{0, 0, 1});
    tbl.push_back('{127, 127, 1});
    tbl.push_back('{127, 508, 1});
    tbl.push_back('{127, 1397, 1});
    tbl.push_back('{127, 2921, 1});
    tbl.push_back('{127, 4445, 1});
    tbl.push_back('{127, 5334, 1});
    tbl.push_back('{127, 5715, 1});
    tbl.push_back('{127, 5842, 1});
    tbl.push_back('{127, 5842, 1});
    for (int i = 0; i < 7; i++) tbl.push_back('{-128, 0, 0});
    tbl.push_back('{-128, -5888, 1});
    tbl.push_back('{-128, -5888, 1});

    foreach (tbl[i]) begin
      step(tbl[i].x, tbl[i].x);
      if (tbl[i].chk) check($sformatf("tbl[%0d]", i), int'(y_out), tbl[i].exp);
      check($sformatf("tbl_sat[%0d]", i), int'(y_sat), ref_y(hs, cs));
    end

    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, 127);
      check_model("sat_pos");
      if (i >= 2) check("sat_pos_clip", int'(y_sat), 32767);
    end
    for (int i = 0; i < 9; i++) begin
      step(0, -128);
      check_model("sat_neg");
      if (i >= 7) check("sat_neg_clip", int'(y_sat), -32768);
    end

    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      step(127, 127);
      check_model("pre_rst_step");
    end
    pulse_reset();
    step(1, 1);
    check("mid_rst_imp0", int'(y_out), 1);
    for (int i = 1; i < 8; i++) begin
      step(0, 0);
      check($sformatf("mid_rst_imp%0d", i), int'(y_out), cd[i]);
    end
    step(0, 0);
    check("mid_rst_tail", int'(y_out), 0);

    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
